// File: rtl/led_pattern_ctrl.sv
// Bi-colour front-panel LED driver: per-channel mode codes, shared slow/fast blink timebases,
// fault stretching, power gating and an optional lamp test (enabled by defining LED_LAMPTEST_EN).
module led_pattern_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int SLOW_HALF  = 32,
    parameter int FAST_HALF  = 8,
    parameter int HOLD_TICKS = 64,
    parameter int LT_TICKS   = 32
) (
    input  logic                SlowClock,
    input  logic                Reset,
    input  logic                Strobe16ms,
    input  logic                PwrOn,
    input  logic [3*NUM_CH-1:0] ModeReg,
    input  logic [NUM_CH-1:0]   Fault,
    input  logic                LampTest,
    output logic [NUM_CH-1:0]   LedG_N,
    output logic [NUM_CH-1:0]   LedR_N,
    output logic                LampTestBusy
);

    localparam int SW = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
    localparam int FW = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int LW = (LT_TICKS > 1) ? $clog2(LT_TICKS) : 1;

    logic [SW-1:0] slow_cnt_r;
    logic [FW-1:0] fast_cnt_r;
    logic          slow_ph_r;
    logic          fast_ph_r;
    logic [HW-1:0] hold_cnt_r [NUM_CH];
    logic [1:0]    lit_s      [NUM_CH];
    logic          lt_green_s;
    logic          lt_red_s;

    // Mode code to {green, red} lit pattern for the current blink phases.
    function automatic logic [1:0] mode_decode(input logic [2:0] mode, input logic sph,
                                               input logic fph);
        logic [1:0] gr;
        case (mode)
            3'd0:    gr = 2'b00;
            3'd1:    gr = 2'b10;
            3'd2:    gr = 2'b01;
            3'd3:    gr = 2'b11;
            3'd4:    gr = {sph, 1'b0};
            3'd5:    gr = {1'b0, sph};
            3'd6:    gr = {fph, 1'b0};
            3'd7:    gr = {sph, ~sph};
            default: gr = 2'b00;
        endcase
        return gr;
    endfunction

    // Shared slow/fast blink timebases, advanced only on strobe cycles.
    always_ff @(posedge SlowClock) begin
        if (Reset) begin
            slow_cnt_r <= {SW{1'b0}};
            fast_cnt_r <= {FW{1'b0}};
            slow_ph_r  <= 1'b1;
            fast_ph_r  <= 1'b1;
        end else if (Strobe16ms) begin
            if (slow_cnt_r == SW'(SLOW_HALF - 1)) begin
                slow_cnt_r <= {SW{1'b0}};
                slow_ph_r  <= ~slow_ph_r;
            end else begin
                slow_cnt_r <= slow_cnt_r + SW'(1);
            end
            if (fast_cnt_r == FW'(FAST_HALF - 1)) begin
                fast_cnt_r <= {FW{1'b0}};
                fast_ph_r  <= ~fast_ph_r;
            end else begin
                fast_cnt_r <= fast_cnt_r + FW'(1);
            end
        end
    end

    // Fault stretch: a live fault reloads the hold, strobes drain it (load wins over drain).
    always_ff @(posedge SlowClock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (Reset) begin
                hold_cnt_r[i] <= {HW{1'b0}};
            end else if (Fault[i]) begin
                hold_cnt_r[i] <= HW'(HOLD_TICKS);
            end else if (Strobe16ms && (hold_cnt_r[i] != {HW{1'b0}})) begin
                hold_cnt_r[i] <= hold_cnt_r[i] - HW'(1);
            end
        end
    end

`ifdef LED_LAMPTEST_EN
    typedef enum logic [1:0] {
        LT_IDLE  = 2'd0,
        LT_GREEN = 2'd1,
        LT_RED   = 2'd2
    } lt_state_t;

    lt_state_t     lt_state_r;
    lt_state_t     lt_state_s;
    logic [LW-1:0] lt_cnt_r;
    logic [LW-1:0] lt_cnt_s;

    // Lamp-test state and phase-strobe counter registers.
    always_ff @(posedge SlowClock) begin
        if (Reset) begin
            lt_state_r <= LT_IDLE;
            lt_cnt_r   <= {LW{1'b0}};
        end else begin
            lt_state_r <= lt_state_s;
            lt_cnt_r   <= lt_cnt_s;
        end
    end

    // Lamp-test sequencing; losing power abandons the test immediately.
    always_comb begin
        lt_state_s = lt_state_r;
        lt_cnt_s   = lt_cnt_r;
        if (!PwrOn) begin
            lt_state_s = LT_IDLE;
            lt_cnt_s   = {LW{1'b0}};
        end else begin
            case (lt_state_r)
                LT_IDLE: begin
                    if (LampTest) begin
                        lt_state_s = LT_GREEN;
                        lt_cnt_s   = {LW{1'b0}};
                    end else begin
                        lt_state_s = LT_IDLE;
                    end
                end
                LT_GREEN, LT_RED: begin
                    if (Strobe16ms && (lt_cnt_r == LW'(LT_TICKS - 1))) begin
                        lt_state_s = (lt_state_r == LT_GREEN) ? LT_RED : LT_IDLE;
                        lt_cnt_s   = {LW{1'b0}};
                    end else if (Strobe16ms) begin
                        lt_cnt_s = lt_cnt_r + LW'(1);
                    end else begin
                        lt_cnt_s = lt_cnt_r;
                    end
                end
                default: begin
                    lt_state_s = LT_IDLE;
                    lt_cnt_s   = {LW{1'b0}};
                end
            endcase
        end
    end

    assign lt_green_s   = (lt_state_r == LT_GREEN);
    assign lt_red_s     = (lt_state_r == LT_RED);
    assign LampTestBusy = (lt_state_r != LT_IDLE);
`else
    logic unused_lamptest_s;

    assign unused_lamptest_s = LampTest;
    assign lt_green_s        = 1'b0;
    assign lt_red_s          = 1'b0;
    assign LampTestBusy      = 1'b0;
`endif

    // Per-channel display selection: power gate > lamp test > fault > mode.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            lit_s[i] = 2'b00;
            if (!PwrOn) begin
                lit_s[i] = 2'b00;
            end else if (lt_green_s) begin
                lit_s[i] = 2'b10;
            end else if (lt_red_s) begin
                lit_s[i] = 2'b01;
            end else if (Fault[i] || (hold_cnt_r[i] != {HW{1'b0}})) begin
                lit_s[i] = {1'b0, fast_ph_r};
            end else begin
                lit_s[i] = mode_decode(ModeReg[3*i +: 3], slow_ph_r, fast_ph_r);
            end
        end
    end

    // Registered active-low pin drivers.
    always_ff @(posedge SlowClock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (Reset) begin
                LedG_N[i] <= 1'b1;
                LedR_N[i] <= 1'b1;
            end else begin
                LedG_N[i] <= ~lit_s[i][1];
                LedR_N[i] <= ~lit_s[i][0];
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: directed scenarios then randomized traffic, all
// compared each cycle against a strobe-count based reference model.
module tb_led_pattern_ctrl;

    localparam int NUM_CH     = 4;
    localparam int SLOW_HALF  = 32;
    localparam int FAST_HALF  = 8;
    localparam int HOLD_TICKS = 64;
    localparam int LT_TICKS   = 32;

    logic                SlowClock = 1'b0;
    logic                Reset;
    logic                Strobe16ms;
    logic                PwrOn;
    logic [3*NUM_CH-1:0] ModeReg;
    logic [NUM_CH-1:0]   Fault;
    logic                LampTest;
    logic [NUM_CH-1:0]   LedG_N;
    logic [NUM_CH-1:0]   LedR_N;
    logic                LampTestBusy;

    int checks   = 0;
    int failures = 0;

    // Reference model state: strobes since reset, strobe-count marks of last fault, lamp phase.
    int strobes;
    int fault_mark [NUM_CH];
    bit marked     [NUM_CH];
    int lt_phase;
    int lt_cnt;

    always #5 SlowClock = ~SlowClock;

    led_pattern_ctrl #(
        .NUM_CH(NUM_CH), .SLOW_HALF(SLOW_HALF), .FAST_HALF(FAST_HALF),
        .HOLD_TICKS(HOLD_TICKS), .LT_TICKS(LT_TICKS)
    ) dut (
        .SlowClock(SlowClock), .Reset(Reset), .Strobe16ms(Strobe16ms), .PwrOn(PwrOn),
        .ModeReg(ModeReg), .Fault(Fault), .LampTest(LampTest),
        .LedG_N(LedG_N), .LedR_N(LedR_N), .LampTestBusy(LampTestBusy)
    );

    function automatic bit green_lit(input int mode, input bit sph, input bit fph);
        return (mode == 1) || (mode == 3) || (mode == 4 && sph) || (mode == 6 && fph) ||
               (mode == 7 && sph);
    endfunction

    function automatic bit red_lit(input int mode, input bit sph);
        return (mode == 2) || (mode == 3) || (mode == 5 && sph) || (mode == 7 && !sph);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: predict pins from model + current inputs, advance the model, compare.
    task automatic tick(input bit stb);
        logic [NUM_CH-1:0] eg;
        logic [NUM_CH-1:0] er;
        bit eb, sph, fph, flt, g, r;
        int mode;
        Strobe16ms = stb;
        eg = '1;
        er = '1;
        eb = 1'b0;
        if (Reset) begin
            strobes  = 0;
            lt_phase = 0;
            lt_cnt   = 0;
            for (int c = 0; c < NUM_CH; c++) marked[c] = 1'b0;
        end else begin
            sph = ((strobes / SLOW_HALF) % 2) == 0;
            fph = ((strobes / FAST_HALF) % 2) == 0;
            for (int c = 0; c < NUM_CH; c++) begin
                mode = int'(ModeReg[3*c +: 3]);
                flt  = Fault[c] || (marked[c] && (strobes - fault_mark[c]) < HOLD_TICKS);
                if (!PwrOn)             begin g = 0;   r = 0;   end
                else if (lt_phase == 1) begin g = 1;   r = 0;   end
                else if (lt_phase == 2) begin g = 0;   r = 1;   end
                else if (flt)           begin g = 0;   r = fph; end
                else begin g = green_lit(mode, sph, fph); r = red_lit(mode, sph); end
                eg[c] = !g;
                er[c] = !r;
                if (Fault[c]) begin
                    marked[c]     = 1'b1;
                    fault_mark[c] = strobes + int'(stb);
                end
            end
`ifdef LED_LAMPTEST_EN
            if (!PwrOn) begin
                lt_phase = 0;
                lt_cnt   = 0;
            end else if (lt_phase == 0) begin
                if (LampTest) begin
                    lt_phase = 1;
                    lt_cnt   = 0;
                end
            end else if (stb) begin
                lt_cnt++;
                if (lt_cnt == LT_TICKS) begin
                    lt_phase = (lt_phase == 1) ? 2 : 0;
                    lt_cnt   = 0;
                end
            end
`endif
            strobes += int'(stb);
            eb = (lt_phase != 0);
        end
        @(posedge SlowClock);
        #1;
        LampTest = 1'b0;
        check("led_g", 32'(LedG_N), 32'(eg));
        check("led_r", 32'(LedR_N), 32'(er));
        check("busy", 32'(LampTestBusy), 32'(eb));
    endtask

    task automatic run_strobes(input int n);
        for (int k = 0; k < n; k++) begin
            tick(1'b1);
            tick(1'b0);
        end
    endtask

    initial begin
        int tog0, tog1;
        logic prev0, prev1;

        // Reset with every channel in mode 1, then release.
        Reset = 1'b1; PwrOn = 1'b1; Strobe16ms = 1'b0; LampTest = 1'b0;
        Fault = '0; ModeReg = 12'h249;
        for (int k = 0; k < 3; k++) tick(1'b0);
        check("reset_g", 32'(LedG_N), 32'hF);
        check("reset_busy", 32'(LampTestBusy), 32'h0);
        Reset = 1'b0;
        tick(1'b0);
        check("release_g", 32'(LedG_N), 32'h0);
        check("release_r", 32'(LedR_N), 32'hF);

        // Slow blink on ch0, fast blink on ch1, count pin toggles over 200 strobes.
        ModeReg = {3'd1, 3'd1, 3'd6, 3'd4};
        tog0 = 0; tog1 = 0;
        prev0 = LedG_N[0]; prev1 = LedG_N[1];
        for (int k = 0; k < 200; k++) begin
            tick(1'b1);
            tick(1'b0);
            if (LedG_N[0] !== prev0) tog0++;
            if (LedG_N[1] !== prev1) tog1++;
            prev0 = LedG_N[0]; prev1 = LedG_N[1];
        end
        check("slow_toggles", 32'(tog0), 32'd6);
        check("fast_toggles", 32'(tog1), 32'd25);

        // Fault pulse on ch2 (mode 1), re-pulse after 40 strobes, then let it expire.
        Fault = 4'b0100; tick(1'b0); Fault = '0;
        run_strobes(40);
        check("fault_g_off", 32'(LedG_N[2]), 32'h1);
        Fault = 4'b0100; tick(1'b0); Fault = '0;
        run_strobes(63);
        check("hold_still_on", 32'(LedG_N[2]), 32'h1);
        run_strobes(2);
        check("hold_expired", 32'(LedG_N[2]), 32'h0);

        // Power off with modes and faults active, then restore.
        ModeReg = {3'd7, 3'd3, 3'd5, 3'd2};
        Fault = 4'b1010; PwrOn = 1'b0;
        run_strobes(10);
        check("pwroff_g", 32'(LedG_N), 32'hF);
        check("pwroff_r", 32'(LedR_N), 32'hF);
        Fault = '0; PwrOn = 1'b1;
        run_strobes(20);

`ifdef LED_LAMPTEST_EN
        // Lamp test: full run with an ignored second request, then a power-off abort.
        ModeReg = 12'h249;
        run_strobes(80);
        LampTest = 1'b1; tick(1'b0);
        for (int k = 1; k <= 70; k++) begin
            if (k == 10) LampTest = 1'b1;
            tick(1'b1);
            tick(1'b0);
        end
        LampTest = 1'b1; tick(1'b0);
        run_strobes(40);
        PwrOn = 1'b0; tick(1'b0);
        check("abort_busy", 32'(LampTestBusy), 32'h0);
        PwrOn = 1'b1; run_strobes(5);
`else
        // Lamp-test request has no effect; alternate mode never lights both colours.
        ModeReg = {3'd7, 3'd7, 3'd7, 3'd7};
        LampTest = 1'b1; tick(1'b0);
        check("no_busy", 32'(LampTestBusy), 32'h0);
        for (int k = 0; k < 80; k++) begin
            tick(1'b1);
            check("alt_exclusive", 32'(LedG_N | LedR_N), 32'hF);
        end
`endif

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            Reset = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 49) == 0) ModeReg = 12'($urandom);
            for (int c = 0; c < NUM_CH; c++) Fault[c] = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 99) == 0) PwrOn = ~PwrOn;
            else if (!PwrOn && $urandom_range(0, 9) == 0) PwrOn = 1'b1;
            LampTest = ($urandom_range(0, 199) == 0);
            tick($urandom_range(0, 2) == 0);
        end
        Reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
